// File: rtl/shr16_serial_tx_ctrl.sv
// ---------------------------------------------------------------------------
// shr16_serial_tx_ctrl
// Sequences an external right-shift register as an LSB-first serializer.
// A start in IDLE loads the register and then emits len bits over a
// valid/ready serial handshake. Each accepted bit is shifted out of the
// register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      request to send one word (sampled in IDLE only)
//   len        number of bits for this request, legal 1..WIDTH
//   abort      synchronous cancel of an active burst
//   ready      high in IDLE; start is accepted only then
//   sreg_ld    load strobe to the shift register
//   sreg_shr   shift-right strobe to the shift register
//   sreg_lsb   bit 0 of the shift register
//   ser_valid  serial bit valid
//   ser_ready  consumer accepts the bit
//   ser_bit    serial data (the register LSB while sending)
//   ser_last   marks the final bit of the burst
//   done       one-cycle pulse after the last bit is accepted
//   err        one-cycle pulse after a start with an illegal len
//
// ready, sreg_ld, sreg_shr, ser_valid, ser_bit and ser_last are
// combinational functions of state and inputs. The load strobe must fire
// in the same cycle as the start, so these cannot be registered.
// done and err are registered.
// ---------------------------------------------------------------------------
module shr16_serial_tx_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             ready,
  output logic             sreg_ld,
  output logic             sreg_shr,
  input  logic             sreg_lsb,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             len_ok;

  // A length is legal when it is non-zero and no larger than the register.
  assign len_ok = (len != '0) && (len <= CNT_W'(WIDTH));

  // Next-state, counter and strobe logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ready     = 1'b0;
    sreg_ld   = 1'b0;
    sreg_shr  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (len_ok) begin
            sreg_ld   = 1'b1;
            cnt_nxt   = len;
            state_nxt = S_SEND;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      S_SEND: begin
        ser_valid = 1'b1;
        ser_bit   = sreg_lsb;
        ser_last  = (cnt == CNT_W'(1));
        // abort takes priority over a simultaneous handshake.
        if (abort) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (ser_ready) begin
          sreg_shr = 1'b1;
          cnt_nxt  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_shr16_serial_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shr16_serial_tx_ctrl
// Directed bench for shr16_serial_tx_ctrl. It holds the 16-bit shift
// register that the controller drives. A transaction-level model predicts
// every output on every cycle from the inputs alone. Literal checks pin
// the model to hand-computed results.
// ---------------------------------------------------------------------------
module tb_shr16_serial_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] len = 5'd0;
  logic       abort = 1'b0;
  logic       ser_ready = 1'b0;
  logic       ready, sreg_ld, sreg_shr, sreg_lsb;
  logic       ser_valid, ser_bit, ser_last, done, err;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] sr = 16'h0000;

  int n_vec = 0;
  int n_bad = 0;
  int cyc_n = 0;

  shr16_serial_tx_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .ready     (ready),
    .sreg_ld   (sreg_ld),
    .sreg_shr  (sreg_shr),
    .sreg_lsb  (sreg_lsb),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Shift register owned by the environment, driven by the controller strobes.
  always @(posedge clk) begin
    if (sreg_ld)       sr <= data_in;
    else if (sreg_shr) sr <= {1'b0, sr[15:1]};
  end
  assign sreg_lsb = sr[0];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc_n, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_rem  : bits still to be sent of the current word (0 = not sending)
  // m_idx  : index in m_word of the bit on the wire
  // m_done : done pulse due this cycle (the controller is busy, not ready)
  // m_err  : err pulse due this cycle
  int          m_rem  = 0;
  int          m_idx  = 0;
  logic [15:0] m_word = 16'h0000;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;

  always @(posedge clk or negedge rst) begin
    bit was_done;
    if (!rst) begin
      m_rem  = 0;
      m_idx  = 0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      m_err    = 1'b0;
      if (m_rem > 0) begin
        if (abort) begin
          m_rem = 0;
        end else if (ser_ready) begin
          m_idx++;
          m_rem--;
          if (m_rem == 0) m_done = 1'b1;
        end
      end else if (!was_done) begin
        if (start) begin
          if (len >= 5'd1 && len <= 5'd16) begin
            m_word = data_in;
            m_rem  = int'(len);
            m_idx  = 0;
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] model_out();
    logic sending, idle;
    logic bit_v;
    sending = (m_rem > 0);
    idle    = !sending && !m_done;
    bit_v   = sending ? m_word[m_idx[3:0]] : 1'b0;
    return {idle,
            idle && start && (len >= 5'd1) && (len <= 5'd16),
            sending && ser_ready && !abort,
            sending,
            bit_v,
            sending && (m_rem == 1),
            m_done,
            m_err};
  endfunction

  // ---------------- per-cycle compare and transfer capture ----------------
  logic [15:0] cap_bits;
  int cap_n, shr_n, ld_n, done_n, err_n, last_n;
  int t_ld, t_last, t_done;

  task automatic clr();
    cap_bits = 16'h0;
    cap_n = 0; shr_n = 0; ld_n = 0; done_n = 0; err_n = 0; last_n = 0;
    t_ld = -1; t_last = -1; t_done = -1;
  endtask

  always @(negedge clk) begin
    chk("outputs{rdy,ld,shr,vld,bit,last,done,err}",
        32'({ready, sreg_ld, sreg_shr, ser_valid, ser_bit, ser_last, done, err}),
        32'(model_out()));
    if (sreg_ld && sreg_shr) chk("ld_and_shr_exclusive", 32'd1, 32'd0);
    if (sreg_ld) begin ld_n++; t_ld = cyc_n; end
    if (sreg_shr) shr_n++;
    if (done) begin done_n++; t_done = cyc_n; end
    if (err) err_n++;
    if (ser_valid && ser_ready && !abort) begin
      if (cap_n < 16) cap_bits[cap_n] = ser_bit;
      cap_n++;
      if (ser_last) begin last_n++; t_last = cyc_n; end
    end
  end

  // Apply one cycle of inputs, then advance past the next rising edge.
  task automatic cyc(input logic s, input logic [4:0] l, input logic a, input logic r);
    start = s; len = l; abort = a; ser_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    // Reset state
    #3;
    chk("reset_outputs", 32'({ready, sreg_ld, sreg_shr, ser_valid, ser_last, done, err}),
        32'(7'b1000000));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 0, 0, 0);

    // Full burst: 0xA5C3, len 16, ser_ready held high
    clr();
    data_in = 16'hA5C3;
    cyc(1, 5'd16, 0, 1);
    data_in = 16'hFFFF;
    repeat (18) cyc(0, 0, 0, 1);
    chk("full_bits", 32'(cap_bits), 32'h0000A5C3);
    chk("full_count", 32'(cap_n), 32'd16);
    chk("full_shr_pulses", 32'(shr_n), 32'd16);
    chk("full_done_pulses", 32'(done_n), 32'd1);
    chk("full_last_pulses", 32'(last_n), 32'd1);
    chk("full_last_latency", 32'(t_last - t_ld), 32'd16);
    chk("full_done_latency", 32'(t_done - t_ld), 32'd17);

    // Short burst with backpressure: 0x000D, len 3, ready 1,0,0,1,0,1
    clr();
    data_in = 16'h000D;
    cyc(1, 5'd3, 0, 0);
    data_in = 16'h0000;
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("bp_bits", 32'(cap_bits[2:0]), 32'h5);
    chk("bp_count", 32'(cap_n), 32'd3);
    chk("bp_shr_pulses", 32'(shr_n), 32'd3);
    chk("bp_done_pulses", 32'(done_n), 32'd1);

    // Illegal lengths 0 and 17
    clr();
    data_in = 16'h1234;
    cyc(1, 5'd0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 5'd17, 0, 0);
    cyc(0, 0, 0, 0);
    chk("illegal_ld_pulses", 32'(ld_n), 32'd0);
    chk("illegal_err_pulses", 32'(err_n), 32'd2);
    chk("illegal_ready", 32'(ready), 32'd1);

    // Abort together with ser_ready on the 4th bit of an 8-bit burst
    clr();
    data_in = 16'h3C5A;
    cyc(1, 5'd8, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("abort_ready_next", 32'(ready), 32'd1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("abort_bits", 32'(cap_bits[2:0]), 32'h2);
    chk("abort_count", 32'(cap_n), 32'd3);
    chk("abort_shr_pulses", 32'(shr_n), 32'd3);
    chk("abort_done_pulses", 32'(done_n), 32'd0);

    // Reset mid-burst with 5 bits outstanding, then a fresh 2-bit burst
    clr();
    data_in = 16'h007F;
    cyc(1, 5'd7, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 32'({ready, sreg_ld, sreg_shr, ser_valid, ser_last, done, err}),
        32'(7'b1000000));
    @(posedge clk);
    #1 rst = 1'b1;
    chk("midrst_done_pulses", 32'(done_n), 32'd0);
    clr();
    data_in = 16'h0002;
    cyc(1, 5'd2, 0, 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("postrst_bits", 32'(cap_bits[1:0]), 32'h2);
    chk("postrst_done_pulses", 32'(done_n), 32'd1);

    // Starts during SEND and DONE are ignored
    clr();
    data_in = 16'h00B6;
    cyc(1, 5'd4, 0, 1);
    data_in = 16'hFFFF;
    cyc(1, 5'd4, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 5'd5, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("busy_ld_pulses", 32'(ld_n), 32'd1);
    chk("busy_bits", 32'(cap_bits[3:0]), 32'h6);
    chk("busy_count", 32'(cap_n), 32'd4);
    chk("busy_done_pulses", 32'(done_n), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
